// File: rtl/clock_meter.sv
// clock_meter: period (and, with CLOCK_METER_DUTY_EN, high time) of async sig_in in clk cycles.
// One registered result per sig_in rising edge, 3 clk after sig_in is first sampled high; no backpressure.
module clock_meter #(
  parameter int unsigned LEN     = 26,
  parameter int unsigned TIMEOUT = 50000000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sig_in,
  output logic [LEN-1:0] period,
  output logic           period_valid,
  output logic           locked,
  output logic           stall,
  output logic [LEN-1:0] high_time
);

  if (64'(TIMEOUT) >= (64'd1 << LEN)) begin : g_bad_timeout
    $error("clock_meter: TIMEOUT must be below 2**LEN");
  end

  localparam logic [LEN-1:0] TMAX = LEN'(TIMEOUT);
  localparam logic [LEN-1:0] ONE  = LEN'(1);
  localparam logic [0:0]     IDLE = 1'b0;
  localparam logic [0:0]     MEAS = 1'b1;

  logic           s1, s2, s3;
  logic           rise;
  logic [0:0]     state;
  logic [LEN-1:0] ctr;

  assign rise = s2 & ~s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // The counter only runs while measuring; the timeout check keeps it from wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ctr          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      stall        <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (state == IDLE) begin
        if (rise) begin
          state <= MEAS;
          ctr   <= ONE;
          stall <= 1'b0;
        end
      end else begin
        if (rise) begin
          period       <= ctr;
          period_valid <= 1'b1;
          locked       <= 1'b1;
          ctr          <= ONE;
        end else if (ctr == TMAX) begin
          state  <= IDLE;
          stall  <= 1'b1;
          locked <= 1'b0;
        end else begin
          ctr <= ctr + ONE;
        end
      end
    end
  end

`ifdef CLOCK_METER_DUTY_EN
  logic           fall;
  logic           hseen;
  logic [LEN-1:0] hctr;
  logic [LEN-1:0] hlatch;

  assign fall = ~s2 & s3;

  // A period with no falling edge (e.g. stuck high between two rises) reports high_time = period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hctr      <= '0;
      hlatch    <= '0;
      hseen     <= 1'b0;
      high_time <= '0;
    end else begin
      if (rise) begin
        hctr <= ONE;
      end else if (state == MEAS && s2) begin
        hctr <= hctr + ONE;
      end

      if (state == IDLE) begin
        if (rise) begin
          hlatch <= '0;
          hseen  <= 1'b0;
        end
      end else if (rise) begin
        high_time <= hseen ? hlatch : ctr;
        hseen     <= 1'b0;
      end else if (ctr == TMAX) begin
        hlatch <= '0;
        hseen  <= 1'b0;
      end else if (fall) begin
        hlatch <= hctr;
        hseen  <= 1'b1;
      end
    end
  end
`else
  assign high_time = '0;
`endif

endmodule

// File: tb/tb_clock_meter.sv
// Directed bench for clock_meter: dut_a uses default parameters, dut_b uses LEN=8, TIMEOUT=100.
module tb_clock_meter;

`ifdef CLOCK_METER_DUTY_EN
  localparam int EXP_H = 3;
`else
  localparam int EXP_H = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sig_in = 1'b0;
  logic [25:0] a_period, a_high;
  logic        a_vld, a_locked, a_stall;
  logic [7:0]  b_period, b_high;
  logic        b_vld, b_locked, b_stall;

  clock_meter dut_a (
    .clk(clk), .rst(rst), .sig_in(sig_in),
    .period(a_period), .period_valid(a_vld), .locked(a_locked),
    .stall(a_stall), .high_time(a_high)
  );

  clock_meter #(.LEN(8), .TIMEOUT(100)) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig_in),
    .period(b_period), .period_valid(b_vld), .locked(b_locked),
    .stall(b_stall), .high_time(b_high)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int p;
    int h;
  } rec_t;

  rec_t qa[$];
  rec_t qb[$];
  int   rises[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   b_stall_cnt = 0;
  int   consec = 0;
  logic a_vld_q = 1'b0, b_vld_q = 1'b0, b_stall_q = 1'b0;
  rec_t ra, rb;

  always @(negedge clk) begin
    if (a_vld) begin
      ra.c = cyc; ra.p = int'(a_period); ra.h = int'(a_high);
      qa.push_back(ra);
    end
    if (b_vld) begin
      rb.c = cyc; rb.p = int'(b_period); rb.h = int'(b_high);
      qb.push_back(rb);
    end
    if ((a_vld && a_vld_q) || (b_vld && b_vld_q)) consec++;
    if (b_stall && !b_stall_q) b_stall_cnt++;
    a_vld_q   = a_vld;
    b_vld_q   = b_vld;
    b_stall_q = b_stall;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Hold sig_in at v for n clk edges; returns just after the last edge.
  task automatic drive(input logic v, input int n);
    if (v && !sig_in) rises.push_back(cyc);
    sig_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wave(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, h);
      drive(1'b0, p - h);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t0;
    int seen;
    int sc;

    @(posedge clk);
    #1;
    // Reset held while sig_in toggles
    for (int i = 0; i < 10; i++) drive(i[0], 1);
    check("rst_period", a_period, 0);
    check("rst_valid", a_vld, 0);
    check("rst_locked", a_locked, 0);
    check("rst_stall", a_stall, 0);
    check("rst_high", a_high, 0);
    check("rst_b_period", b_period, 0);
    check("rst_no_pulses", qa.size(), 0);
    drive(1'b0, 4);
    rst = 1'b1;
    drive(1'b0, 3);

    // Period 10, 5 rising edges
    qa.delete();
    rises.delete();
    drive(1'b1, 5);
    drive(1'b0, 5);
    check("first_rise_no_valid", qa.size(), 0);
    check("first_rise_unlocked", a_locked, 0);
    wave(10, 5, 4);
    check("p10_count", qa.size(), 4);
    for (int i = 0; i < qa.size(); i++) check("p10_period", qa[i].p, 10);
    for (int i = 1; i < qa.size(); i++) check("p10_spacing", qa[i].c - qa[i-1].c, 10);
    if (qa.size() > 0 && rises.size() > 1) check("p10_latency", qa[0].c - rises[1], 3);
    check("p10_locked", a_locked, 1);

    // Minimum period: toggle every clk
    qa.delete();
    wave(2, 1, 10);
    drive(1'b0, 4);
    check("p2_count", qa.size(), 10);
    for (int i = 1; i < qa.size(); i++) check("p2_period", qa[i].p, 2);

    qa.delete();
    wave(1000, 500, 3);
    drive(1'b0, 4);
    check("p1000_count", qa.size(), 3);
    for (int i = 1; i < qa.size(); i++) check("p1000_period", qa[i].p, 1000);
    check("p1000_locked", a_locked, 1);

    // Timeout on dut_b
    rst = 1'b0;
    drive(1'b0, 3);
    rst = 1'b1;
    drive(1'b0, 3);
    qb.delete();
    wave(20, 10, 4);
    check("p20_count", qb.size(), 3);
    for (int i = 0; i < qb.size(); i++) check("p20_period", qb[i].p, 20);
    check("p20_locked", b_locked, 1);
    check("p20_no_stall", b_stall, 0);
    t0 = (qb.size() > 0) ? qb[qb.size()-1].c : 0;
    seen = -1;
    for (int i = 0; i < 300 && seen < 0; i++) begin
      @(negedge clk);
      if (b_stall) seen = cyc;
    end
    check("stall_delay", seen - t0, 100);
    check("stall_unlocked", b_locked, 0);
    check("stall_period_held", b_period, 20);
    check("stall_no_valid", qb.size(), 3);
    @(posedge clk);
    #1;
    qb.delete();
    drive(1'b1, 10);
    check("restart_stall_clear", b_stall, 0);
    check("restart_no_valid", qb.size(), 0);
    drive(1'b0, 20);
    drive(1'b1, 10);
    drive(1'b0, 10);
    check("p30_count", qb.size(), 1);
    if (qb.size() > 0) check("p30_period", qb[0].p, 30);

    // Boundary: period exactly TIMEOUT, then TIMEOUT+1
    sc = b_stall_cnt;
    qb.delete();
    drive(1'b0, 80);
    drive(1'b1, 50);
    check("p100_count", qb.size(), 1);
    if (qb.size() > 0) check("p100_period", qb[0].p, 100);
    check("p100_no_stall", b_stall_cnt - sc, 0);
    drive(1'b0, 51);
    drive(1'b1, 10);
    drive(1'b0, 10);
    check("p101_stall", b_stall_cnt - sc, 1);
    check("p101_no_valid", qb.size(), 1);

    // High time on dut_a
    qa.delete();
    wave(12, 3, 4);
    drive(1'b0, 4);
    check("duty_count", qa.size(), 4);
    for (int i = 1; i < qa.size(); i++) begin
      check("duty_period", qa[i].p, 12);
      check("duty_high", qa[i].h, EXP_H);
    end

    // Reset in the middle of a high phase
    drive(1'b0, 6);
    drive(1'b1, 2);
    rst = 1'b0;
    #1;
    check("arst_period", a_period, 0);
    check("arst_high", a_high, 0);
    check("arst_locked", a_locked, 0);
    qa.delete();
    drive(1'b1, 2);
    rst = 1'b1;
    drive(1'b1, 3);
    drive(1'b0, 9);
    wave(12, 3, 2);
    drive(1'b0, 4);
    check("arst_fresh_count", qa.size(), 2);
    for (int i = 0; i < qa.size(); i++) begin
      check("arst_fresh_period", qa[i].p, 12);
      check("arst_fresh_high", qa[i].h, EXP_H);
    end

    check("valid_never_back_to_back", consec, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
